// File: rtl/calc_disp_scan.sv
// Eight-digit multiplexed 7-segment scanner for calc_top with per-frame snapshot
// and whole-display blink while the captured status reports an error.
module calc_disp_scan #(
    parameter int unsigned DIV          = 4,
    parameter int unsigned BLINK_FRAMES = 4,
    parameter bit          INV_SEG      = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] displays [7:0],
    input  logic [1:0] status,
    output logic [6:0] seg,
    output logic [7:0] an,
    output logic [2:0] dig_idx,
    output logic       frame_start
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned FcW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
    localparam logic [FcW-1:0]  FcMax  = FcW'(BLINK_FRAMES - 1);
    localparam logic [6:0]      Blank  = {7{INV_SEG}};

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [6:0]      snap_q [7:0];
    logic [6:0]      snap_d [7:0];
    logic            snap_err_q, snap_err_d;
    logic [FcW-1:0]  frame_cnt_q, frame_cnt_d;
    logic            blink_ph_q, blink_ph_d;
    logic            tick;
    logic            frame_first;
    logic            new_err;

    always_comb begin
        tick        = (cnt_q == CntMax);
        frame_first = (cnt_q == '0) && (idx_q == 3'd0);
        new_err     = (status == 2'b11);
        cnt_d       = tick ? '0 : cnt_q + CntW'(1);
        idx_d       = tick ? idx_q + 3'd1 : idx_q;
        snap_d      = snap_q;
        snap_err_d  = snap_err_q;
        frame_cnt_d = frame_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (frame_first) begin
            snap_d     = displays;
            snap_err_d = new_err;
            // Blink only advances once the error has been held across a frame boundary;
            // a cleared error drops the blink immediately at this frame start.
            if (!new_err) begin
                frame_cnt_d = '0;
                blink_ph_d  = 1'b0;
            end else if (snap_err_q) begin
                if (frame_cnt_q == FcMax) begin
                    frame_cnt_d = '0;
                    blink_ph_d  = ~blink_ph_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + FcW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            snap_q      <= '{default: 7'h00};
            snap_err_q  <= 1'b0;
            frame_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            snap_err_q  <= snap_err_d;
            frame_cnt_q <= frame_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    always_comb begin
        an          = blink_ph_q ? 8'hFF : ~(8'b1 << idx_q);
        seg         = blink_ph_q ? Blank : (snap_q[idx_q] ^ {7{INV_SEG}});
        dig_idx     = idx_q;
        frame_start = frame_first && !reset;
    end

endmodule

// File: tb/tb_calc_disp_scan.sv
// Directed bench for calc_disp_scan: scan order, snapshot, blink, mid-frame reset,
// DIV=1 and inverted segment polarity.
module tb_calc_disp_scan;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] displays [7:0];
    logic [1:0] status = 2'b00;

    logic [6:0] seg_a, seg_b, seg_c;
    logic [7:0] an_a, an_b, an_c;
    logic [2:0] idx_a, idx_b, idx_c;
    logic       fs_a, fs_b, fs_c;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    calc_disp_scan #(.DIV(4), .BLINK_FRAMES(2), .INV_SEG(1'b0)) u_a (
        .clock(clock), .reset(reset), .displays(displays), .status(status),
        .seg(seg_a), .an(an_a), .dig_idx(idx_a), .frame_start(fs_a)
    );

    calc_disp_scan #(.DIV(1), .BLINK_FRAMES(4), .INV_SEG(1'b0)) u_b (
        .clock(clock), .reset(reset), .displays(displays), .status(status),
        .seg(seg_b), .an(an_b), .dig_idx(idx_b), .frame_start(fs_b)
    );

    calc_disp_scan #(.DIV(4), .BLINK_FRAMES(2), .INV_SEG(1'b1)) u_c (
        .clock(clock), .reset(reset), .displays(displays), .status(status),
        .seg(seg_c), .an(an_c), .dig_idx(idx_c), .frame_start(fs_c)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Leaves the bench on the first (frame-start) cycle after release.
    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        #1;
    endtask

    task automatic set_default_displays();
        for (int i = 0; i < 8; i++) displays[i] = 7'(i + 1);
    endtask

    task automatic test_reset();
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        set_default_displays();
        status = 2'b00;
        reset  = 1'b1;
        step(2);
        checks++;
        if (an_a !== 8'hFE) begin errors++; $display("FAIL reset_an: got %h expected fe", an_a); end
        checks++;
        if (seg_a !== 7'h00) begin errors++; $display("FAIL reset_seg: got %h expected 00", seg_a); end
        checks++;
        if (fs_a !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", fs_a); end
        checks++;
        if (idx_a !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", idx_a); end
        reset = 1'b0;
        #1;
        for (int c = 0; c < 32; c++) begin
            exp_an  = ~(8'd1 << (c / 4));
            exp_seg = (c == 0) ? 7'h00 : 7'(c / 4 + 1);
            checks++;
            if (an_a !== exp_an) begin
                errors++; $display("FAIL scan_an c=%0d: got %h expected %h", c, an_a, exp_an);
            end
            checks++;
            if (seg_a !== exp_seg) begin
                errors++; $display("FAIL scan_seg c=%0d: got %h expected %h", c, seg_a, exp_seg);
            end
            checks++;
            if (fs_a !== (c == 0)) begin
                errors++; $display("FAIL scan_fs c=%0d: got %b expected %b", c, fs_a, c == 0);
            end
            step(1);
        end
        checks++;
        if (fs_a !== 1'b1) begin errors++; $display("FAIL frame2_fs: got %b expected 1", fs_a); end
        checks++;
        if (seg_a !== 7'h01) begin errors++; $display("FAIL frame2_seg: got %h expected 01", seg_a); end
    endtask

    // Entered on a frame-start cycle.
    task automatic test_snapshot();
        step(2);
        displays[5] = 7'h7F;
        step(19);
        checks++;
        if (an_a !== 8'hDF) begin errors++; $display("FAIL snap_an: got %h expected df", an_a); end
        checks++;
        if (seg_a !== 7'h06) begin errors++; $display("FAIL snap_old: got %h expected 06", seg_a); end
        step(32);
        checks++;
        if (seg_a !== 7'h7F) begin errors++; $display("FAIL snap_new: got %h expected 7f", seg_a); end
        displays[5] = 7'h06;
        step(11);
        checks++;
        if (fs_a !== 1'b1) begin errors++; $display("FAIL snap_fs: got %b expected 1", fs_a); end
    endtask

    task automatic test_blink();
        logic blank;
        set_default_displays();
        status = 2'b11;
        do_reset();
        step(16);
        for (int n = 0; n < 7; n++) begin
            blank = ((n / 2) % 2) == 1;
            checks++;
            if (an_a !== (blank ? 8'hFF : 8'hEF)) begin
                errors++; $display("FAIL blink_an f=%0d: got %h blank=%b", n, an_a, blank);
            end
            checks++;
            if (seg_a !== (blank ? 7'h00 : 7'h05)) begin
                errors++; $display("FAIL blink_seg f=%0d: got %h blank=%b", n, seg_a, blank);
            end
            checks++;
            if (seg_c !== (blank ? 7'h7F : 7'h7A)) begin
                errors++; $display("FAIL blink_seg_inv f=%0d: got %h blank=%b", n, seg_c, blank);
            end
            if (n == 6) status = 2'b00;
            step(32);
        end
        checks++;
        if (an_a !== 8'hEF) begin errors++; $display("FAIL blink_clear_an: got %h expected ef", an_a); end
        checks++;
        if (seg_a !== 7'h05) begin errors++; $display("FAIL blink_clear_seg: got %h expected 05", seg_a); end
    endtask

    task automatic test_reset_mid();
        set_default_displays();
        status = 2'b11;
        do_reset();
        step(64 + 20);
        checks++;
        if (an_a !== 8'hFF) begin errors++; $display("FAIL mid_pre_an: got %h expected ff", an_a); end
        reset = 1'b1;
        step(1);
        checks++;
        if (an_a !== 8'hFE) begin errors++; $display("FAIL mid_an: got %h expected fe", an_a); end
        checks++;
        if (seg_a !== 7'h00) begin errors++; $display("FAIL mid_seg: got %h expected 00", seg_a); end
        checks++;
        if (idx_a !== 3'd0) begin errors++; $display("FAIL mid_idx: got %0d expected 0", idx_a); end
        displays[0] = 7'h55;
        status      = 2'b00;
        reset       = 1'b0;
        #1;
        checks++;
        if (fs_a !== 1'b1) begin errors++; $display("FAIL mid_fs: got %b expected 1", fs_a); end
        step(1);
        checks++;
        if (seg_a !== 7'h55) begin errors++; $display("FAIL mid_reload: got %h expected 55", seg_a); end
        checks++;
        if (an_a !== 8'hFE) begin errors++; $display("FAIL mid_an2: got %h expected fe", an_a); end
        set_default_displays();
    endtask

    task automatic test_div1();
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        set_default_displays();
        status = 2'b00;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            exp_an  = ~(8'd1 << (c % 8));
            exp_seg = (c == 0) ? 7'h00 : 7'((c % 8) + 1);
            checks++;
            if (an_b !== exp_an) begin
                errors++; $display("FAIL div1_an c=%0d: got %h expected %h", c, an_b, exp_an);
            end
            checks++;
            if (fs_b !== ((c % 8) == 0)) begin
                errors++; $display("FAIL div1_fs c=%0d: got %b", c, fs_b);
            end
            checks++;
            if (idx_b !== 3'(c % 8)) begin
                errors++; $display("FAIL div1_idx c=%0d: got %0d expected %0d", c, idx_b, c % 8);
            end
            checks++;
            if (seg_b !== exp_seg) begin
                errors++; $display("FAIL div1_seg c=%0d: got %h expected %h", c, seg_b, exp_seg);
            end
            step(1);
        end
    endtask

    task automatic test_inv_seg();
        set_default_displays();
        displays[0] = 7'h06;
        status      = 2'b00;
        reset       = 1'b1;
        step(1);
        checks++;
        if (seg_c !== 7'h7F) begin errors++; $display("FAIL inv_reset_seg: got %h expected 7f", seg_c); end
        checks++;
        if (an_c !== 8'hFE) begin errors++; $display("FAIL inv_reset_an: got %h expected fe", an_c); end
        reset = 1'b0;
        #1;
        step(1);
        checks++;
        if (seg_c !== 7'h79) begin errors++; $display("FAIL inv_seg: got %h expected 79", seg_c); end
        checks++;
        if (seg_a !== 7'h06) begin errors++; $display("FAIL noninv_seg: got %h expected 06", seg_a); end
        set_default_displays();
    endtask

    initial begin
        set_default_displays();
        test_reset();
        test_snapshot();
        test_blink();
        test_reset_mid();
        test_div1();
        test_inv_seg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_disp_scan.md
Name: calc_disp_scan

Overview:
- Downstream display stage for calc_top.
- Consumes calc_top's eight 7-segment digit patterns (displays[7:0]) and its 2-bit status.
- Time-multiplexes the digits onto one shared segment bus with active-low digit enables, for a board with a single common-segment 8-digit display.
- Latches a full-frame snapshot so a frame never shows a mix of old and new values, and blinks the whole display while calc_top reports error.

Parameters:
- DIV, 4: clock cycles each digit stays enabled (>=1; board builds use ~50000).
- BLINK_FRAMES, 4: full scan frames per blink half-period (>=1).
- INV_SEG, 0: 1 inverts seg output polarity, and the blank value becomes 7'h7F.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- displays, input, 7 x [7:0] (unpacked array [7:0] of [6:0]): per-digit segment pattern from calc_top; index 0 is the rightmost digit; bit set = segment lit.
- status, input, 2: calc_top status; 2'b11 = error.
- seg, output, 7: shared segment bus.
- an, output, 8: digit enables, active-low, one-hot-zero.
- dig_idx, output, 3: currently enabled digit index.
- frame_start, output, 1: one-cycle pulse on the first cycle of each frame.

Behaviour:
- Reset is synchronous on the rising edge of clock while reset=1. It overrides everything, including a reset asserted mid-frame or mid-blink.
  - cnt=0, idx=0, snap[*]=7'h00, snap_err=0, frame_cnt=0, blink_ph=0.
  - Resulting outputs during/after reset: an=8'hFE, dig_idx=0, seg=blank (7'h00, or 7'h7F if INV_SEG), frame_start=0.
- Prescaler cnt counts 0..DIV-1 and wraps. tick = (cnt==DIV-1). With DIV=1, tick is every cycle.
- On tick, idx increments, wrapping 7->0. Each digit is enabled for exactly DIV cycles; frame period is 8*DIV cycles.
- Frame start is the condition cnt==0 && idx==0 && !reset. It occurs the first cycle after reset release and then every 8*DIV cycles.
  - On that edge: snap[i] <= displays[i] for all i, and snap_err <= (status==2'b11).
  - frame_start = 1 combinationally during that cycle (registered-state decode only).
- Input changes between frame starts are ignored until the next frame start.
- Blink:
  - If snap_err=0: frame_cnt held at 0 and blink_ph held at 0.
  - If snap_err=1: at each frame start, frame_cnt increments. On reaching BLINK_FRAMES-1 it wraps to 0 and blink_ph toggles.
  - When snap_err clears, frame_cnt and blink_ph return to 0 at the same frame-start edge.
- Outputs are pure decodes of registered state, with no combinational path from displays/status to outputs:
  - an = blink_ph ? 8'hFF : ~(8'b1 << idx).
  - seg = blink_ph ? blank : (snap[idx] ^ {7{INV_SEG}}).
  - dig_idx = idx.
- Latency:
  - A displays change just before a frame start appears on seg when its digit is scanned in that frame (digit k appears k*DIV cycles later).
  - A change just after a frame start appears one frame later.
- Never more than one an bit is low. idx/cnt arithmetic wraps modulo 8 / DIV with no overflow states.

Test Plan:
- Reset then scan, DIV=4, displays[i]=i+1:
  - during reset: an=8'hFE, seg=0.
  - after release: an sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles; seg=1..8 in step; frame_start every 32 cycles.
- Snapshot stability:
  - change displays[5] from 7'h06 to 7'h7F at cycle 2 of a frame -> digit 5 still shows 7'h06 in that frame, shows 7'h7F next frame.
- Error blink, BLINK_FRAMES=2, status=2'b11:
  - 2 frames normal, then 2 frames an=8'hFF and seg blank, repeating.
  - status back to 2'b00 -> normal scan from the next frame start.
- Reset asserted mid-frame at idx=5 while blink_ph=1 -> next edge: an=8'hFE, seg blank, blink off; snapshot reloads on the first cycle after release.
- DIV=1 -> an changes every cycle, frame_start every 8 cycles.
- INV_SEG=1:
  - displays[0]=7'h06 -> seg=7'h79 at digit 0.
  - blank=7'h7F during reset and blink-off.
